pipe_shifter: RTL

- Parametrised two-stage pipelined shift unit for the EX stage of the 5-stage MIPS datapath.
- Replaces fixed-amount shifters such as the constant left-shift-by-2 used for branch offsets.
- Supports SLL, SRL, SRA and ROTR with a variable shift amount, valid/ready handshake, full throughput, and pipeline flush.

---
 rtl/pipe_shifter.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_shifter.sv
// Two-stage pipelined SLL/SRL/SRA/ROTR unit with valid/ready and flush.
// Stage 1 shifts by the high shamt bits, stage 2 by the low bits.
module pipe_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int LO_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int HI_W = SHAMT_W - LO_BITS;

  // SRA fills from the carried sign so stage 2 stays correct after stage 1
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] sh,
    input logic [1:0]         op,
    input logic               sgn
  );
    logic [WIDTH-1:0] r;
    unique case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = WIDTH'($signed({sgn, d}) >>> sh);
      default: r = WIDTH'({d, d} >> sh);
    endcase
    return r;
  endfunction

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_data;
  logic [LO_BITS-1:0] r_s1_lo;
  logic [1:0]         r_s1_op;
  logic               r_s1_sign;
  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_s2_data;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_acc;
  logic [SHAMT_W-1:0] w_hi_sh;
  logic [SHAMT_W-1:0] w_lo_sh;
  logic [WIDTH-1:0]   w_s1_res;
  logic [WIDTH-1:0]   w_s2_res;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !flush && !rst;
  assign w_acc    = in_valid && in_ready;

  assign w_hi_sh = {in_shamt[SHAMT_W-1:LO_BITS], {LO_BITS{1'b0}}};
  assign w_lo_sh = {{HI_W{1'b0}}, r_s1_lo};

  assign w_s1_res = f_shift(in_data, w_hi_sh, in_op,
                            in_data[WIDTH-1]);
  assign w_s2_res = f_shift(r_s1_data, w_lo_sh, r_s1_op,
                            r_s1_sign);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_lo    <= '0;
      r_s1_op    <= '0;
      r_s1_sign  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_acc;
        if (w_acc) begin
          r_s1_data <= w_s1_res;
          r_s1_lo   <= in_shamt[LO_BITS-1:0];
          r_s1_op   <= in_op;
          r_s1_sign <= in_data[WIDTH-1];
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid)
          r_s2_data <= w_s2_res;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

endmodule
